// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, reads imem[pc] onto isr and advances the PC by one per enabled edge.
// Optional build macro IFU_WRAP_EN: defined = PC wraps at end of imem, undefined = PC saturates at the last word.
module ifu #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned PC_W       = 6
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        en,
  output logic [15:0] isr
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(IMEM_DEPTH - 1);

  // Instruction words are driven from outside the block through hierarchical assigns.
  wire  [15:0]     imem [0:IMEM_DEPTH-1];

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pcwire;

  assign pcwire = pc + PC_W'(1);

  // Next PC: only the end-of-memory behaviour differs between builds.
  always_comb begin
    pc_d = pc;
    if (en) begin
`ifdef IFU_WRAP_EN
      pc_d = pcwire;
`else
      if (pc != PC_LAST) begin
        pc_d = pcwire;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else begin
      pc <= pc_d;
    end
  end

  assign isr = imem[pc];

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu; expected PC/isr/pcwire values are hand-derived per step.
// Honours IFU_WRAP_EN for the end-of-memory expectation.
module tb_ifu;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned PW    = 6;

  logic        reset;
  logic        clk;
  logic        en;
  logic [15:0] isr;

  int vectors;
  int miscompares;
  int exp_pc;

  function automatic logic [15:0] mem_val(input int i);
    case (i)
      0: return 16'd3;
      1: return 16'd7;
      2: return 16'd15;
      3: return 16'd31;
      4: return 16'd64;
      5: return 16'd128;
      6: return 16'd255;
      default: return 16'hA000 + 16'(i);
    endcase
  endfunction

  ifu #(.IMEM_DEPTH(DEPTH), .PC_W(PW)) dut (
    .reset(reset),
    .clk  (clk),
    .en   (en),
    .isr  (isr)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    assign dut.imem[g] = mem_val(g);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int p);
    check({tag, " pc"}, 32'(dut.pc), 32'(p));
    check({tag, " isr"}, 32'(isr), 32'(mem_val(p)));
    check({tag, " pcwire"}, 32'(dut.pcwire), 32'((p + 1) % DEPTH));
  endtask

  task automatic edge_step(input string tag, input int p);
    @(posedge clk);
    #1;
    check_state(tag, p);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // 1: reset asserted, no clock edge yet
    reset = 1'b0;
    en    = 1'b1;
    #1;
    check_state("s1 reset", 0);
    // Edges while reset is held do not advance
    edge_step("s1 reset held", 0);

    // 2: release away from an edge, six enabled edges
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_state("s2 release", 0);
    for (int i = 1; i <= 6; i++) edge_step($sformatf("s2 step%0d", i), i);

    // 3: restart, advance to isr=15, then stall three edges
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("s3 reset", 0);
    @(negedge clk);
    reset = 1'b1;
    edge_step("s3 adv1", 1);
    edge_step("s3 adv2", 2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) edge_step($sformatf("s3 hold%0d", i), 2);
    en = 1'b1;
    edge_step("s3 resume", 3);
    edge_step("s3 adv4", 4);
    edge_step("s3 adv5", 5);

    // 4: asynchronous reset midway between edges at pc=5
    @(negedge clk);
    #2;
    check("s4 pre pc", 32'(dut.pc), 32'd5);
    reset = 1'b0;
    #1;
    check_state("s4 async reset", 0);
    @(negedge clk);
    reset = 1'b1;
    edge_step("s4 first adv", 1);

    // 5/6: run to the last word, checking pcwire on every step
    exp_pc = 1;
    while (exp_pc < int'(DEPTH) - 1) begin
      exp_pc++;
      edge_step($sformatf("s5 run%0d", exp_pc), exp_pc);
    end
    check("s5 pcwire at end", 32'(dut.pcwire), 32'd0);
`ifdef IFU_WRAP_EN
    edge_step("s5 wrap", 0);
    edge_step("s5 after wrap", 1);
`else
    edge_step("s5 saturate", int'(DEPTH) - 1);
    edge_step("s5 saturate again", int'(DEPTH) - 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
